// File: rtl/rs232_pkg.sv
// rs232_pkg: line level type, default line voltages and the receive classifier.
package rs232_pkg;
  typedef enum logic [1:0] {LVL_MARK, LVL_SPACE, LVL_UNDEF} rs232_level_e;
  localparam int V_DRIVE_DEF = 12;
  localparam int V_THR_DEF = 3;
  function automatic rs232_level_e classify(input int v, input int thr);
    return v < -thr ? LVL_MARK : (v > thr ? LVL_SPACE : LVL_UNDEF);
  endfunction
endpackage

// File: rtl/rs232_rx_chan.sv
// rs232_rx_chan: one receive channel - input register, hysteresis classifier,
// glitch filter, break detector and undefined-level fault detector.
module rs232_rx_chan
  import rs232_pkg::*;
#(
  parameter int V_W       = 6,
  parameter int V_THR     = V_THR_DEF,
  parameter int FILT_LEN  = 4,
  parameter int BREAK_CYC = 64,
  parameter int FAULT_CYC = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [V_W-1:0] rx_v,
  output logic           uart_rx,
  output logic           break_det,
  output logic           line_fault
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int BW = $clog2(BREAK_CYC + 1);
  localparam int QW = $clog2(FAULT_CYC + 1);
  logic signed [V_W-1:0] v_q, v_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [BW-1:0] brk_q, brk_d;
  logic [QW-1:0] flt_q, flt_d;
  logic rx_q, rx_d, break_q, break_d, fault_q, fault_d;
  rs232_level_e lvl;
  logic opp, flip;
  always_comb begin
    v_d = rx_v;
    lvl = classify(int'(v_q), V_THR);
    opp = (lvl == LVL_MARK && !rx_q) || (lvl == LVL_SPACE && rx_q);
    flip = opp && filt_q == FW'(FILT_LEN - 1);
    filt_d = (flip || (lvl != LVL_UNDEF && !opp)) ? '0 : (opp ? filt_q + 1'b1 : filt_q);
    rx_d = flip ? !rx_q : rx_q;
    brk_d = rx_q ? '0 : (brk_q == BW'(BREAK_CYC) ? brk_q : brk_q + 1'b1);
    break_d = !rx_q && brk_d == BW'(BREAK_CYC);
    flt_d = lvl != LVL_UNDEF ? '0 : (flt_q == QW'(FAULT_CYC) ? flt_q : flt_q + 1'b1);
    fault_d = flt_d == QW'(FAULT_CYC);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      filt_q <= '0;
      brk_q <= '0;
      flt_q <= '0;
      rx_q <= 1'b1;
      break_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      v_q <= v_d;
      filt_q <= filt_d;
      brk_q <= brk_d;
      flt_q <= flt_d;
      rx_q <= rx_d;
      break_q <= break_d;
      fault_q <= fault_d;
    end
  end
  assign uart_rx = rx_q;
  assign break_det = break_q;
  assign line_fault = fault_q;
endmodule

// File: rtl/rs232_phy_mc.sv
// rs232_phy_mc: multi-channel clocked RS-232 PHY (registered drivers + filtered receivers).
// Define RS232_LOOPBACK_EN to add the per-channel lpbk port routing the driver into the receiver.
module rs232_phy_mc
  import rs232_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int V_W       = 6,
  parameter int V_DRIVE   = rs232_pkg::V_DRIVE_DEF,
  parameter int V_THR     = rs232_pkg::V_THR_DEF,
  parameter int FILT_LEN  = 4,
  parameter int BREAK_CYC = 64,
  parameter int FAULT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     uart_tx,
  input  logic [NUM_CH-1:0]     tx_en,
`ifdef RS232_LOOPBACK_EN
  input  logic [NUM_CH-1:0]     lpbk,
`endif
  output logic [NUM_CH*V_W-1:0] rs232_tx,
  input  logic [NUM_CH*V_W-1:0] rs232_rx,
  output logic [NUM_CH-1:0]     uart_rx,
  output logic [NUM_CH-1:0]     break_det,
  output logic [NUM_CH-1:0]     line_fault
);
  logic [NUM_CH*V_W-1:0] drv_q, drv_d, rx_in;
  always_comb begin
    drv_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      drv_d[i*V_W +: V_W] = tx_en[i] ? (uart_tx[i] ? V_W'(-V_DRIVE) : V_W'(V_DRIVE)) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drv_q <= '0;
    else drv_q <= drv_d;
  end
`ifdef RS232_LOOPBACK_EN
  // drv_q keeps the unforced driver value so a looped channel still sees its own TX
  logic [NUM_CH*V_W-1:0] tx_q, tx_d;
  always_comb begin
    tx_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      tx_d[i*V_W +: V_W] = lpbk[i] ? '0 : drv_d[i*V_W +: V_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= '0;
    else tx_q <= tx_d;
  end
  assign rs232_tx = tx_q;
  always_comb begin
    rx_in = '0;
    for (int i = 0; i < NUM_CH; i++)
      rx_in[i*V_W +: V_W] = lpbk[i] ? drv_q[i*V_W +: V_W] : rs232_rx[i*V_W +: V_W];
  end
`else
  assign rs232_tx = drv_q;
  assign rx_in = rs232_rx;
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rs232_rx_chan #(
      .V_W(V_W), .V_THR(V_THR), .FILT_LEN(FILT_LEN),
      .BREAK_CYC(BREAK_CYC), .FAULT_CYC(FAULT_CYC)
    ) u_rx (
      .clk(clk),
      .rst_n(rst_n),
      .rx_v(rx_in[g*V_W +: V_W]),
      .uart_rx(uart_rx[g]),
      .break_det(break_det[g]),
      .line_fault(line_fault[g])
    );
  end
endmodule

// File: tb/tb_rs232_phy_mc.sv
// tb_rs232_phy_mc: directed self-checking bench for rs232_phy_mc.
module tb_rs232_phy_mc;
  localparam logic [5:0] NEG12 = 6'h34;
  localparam logic [5:0] POS12 = 6'h0C;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] uart_tx, tx_en, uart_rx, break_det, line_fault;
  logic [11:0] rs232_tx, rs232_rx;
`ifdef RS232_LOOPBACK_EN
  logic [1:0] lpbk = 2'b00;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rs232_phy_mc dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_tx(uart_tx),
    .tx_en(tx_en),
`ifdef RS232_LOOPBACK_EN
    .lpbk(lpbk),
`endif
    .rs232_tx(rs232_tx),
    .rs232_rx(rs232_rx),
    .uart_rx(uart_rx),
    .break_det(break_det),
    .line_fault(line_fault)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  logic [5:0] und_tbl [3] = '{6'h3D, 6'h00, 6'h03};
  logic [5:0] frz_tbl [7] = '{POS12, POS12, POS12, 6'h00, 6'h00, POS12, NEG12};
  initial begin
    uart_tx = 2'b11;
    tx_en = 2'b11;
    rs232_rx = {NEG12, NEG12};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", rs232_tx, 0);
    chk("rst_rx", uart_rx, 2'b11);
    chk("rst_brk", break_det, 0);
    chk("rst_flt", line_fault, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    tx_en = 2'b01;
    uart_tx = 2'b01;
    tick(1);
    chk("tx_mark", rs232_tx, {6'h00, NEG12});
    uart_tx = 2'b00;
    tick(1);
    chk("tx_space", rs232_tx, {6'h00, POS12});
    tx_en = 2'b00;
    tick(1);
    chk("tx_off", rs232_tx, 0);
    tx_en = 2'b10;
    tick(1);
    chk("tx_ch1", rs232_tx, {POS12, 6'h00});
    tx_en = 2'b00;
    rs232_rx[5:0] = POS12;
    tick(4);
    chk("filt_hold", uart_rx, 2'b11);
    tick(1);
    chk("filt_fall", uart_rx, 2'b10);
    tick(63);
    chk("brk_pre", break_det, 0);
    tick(1);
    chk("brk_rise", break_det, 2'b01);
    tick(16);
    chk("brk_hold", break_det, 2'b01);
    rs232_rx[5:0] = NEG12;
    tick(4);
    chk("rel_hold", {break_det, uart_rx}, 4'b0110);
    tick(1);
    chk("rel_rise", {break_det, uart_rx}, 4'b0111);
    tick(1);
    chk("brk_clr", break_det, 0);
    rs232_rx[5:0] = POS12;
    tick(3);
    rs232_rx[5:0] = NEG12;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("glitch", uart_rx, 2'b11);
    end
    for (int k = 0; k < 40; k++) begin
      rs232_rx[5:0] = und_tbl[k % 3];
      tick(1);
      chk("und_flt", line_fault, k >= 16 ? 2'b01 : 2'b00);
      chk("und_rx", uart_rx, 2'b11);
    end
    rs232_rx[5:0] = NEG12;
    tick(1);
    chk("flt_reg", line_fault, 2'b01);
    tick(1);
    chk("flt_clr", line_fault, 0);
    for (int k = 0; k < 7; k++) begin
      rs232_rx[5:0] = frz_tbl[k];
      tick(1);
      chk("freeze", uart_rx, k >= 6 ? 2'b10 : 2'b11);
    end
    tick(10);
    chk("recover", {break_det, uart_rx}, 4'b0011);
    rs232_rx = {6'h00, POS12};
    tx_en = 2'b11;
    uart_tx = 2'b01;
    tick(20);
    chk("mid_rx", uart_rx, 2'b10);
    chk("mid_flt", line_fault, 2'b10);
    chk("mid_tx", rs232_tx, {POS12, NEG12});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", rs232_tx, 0);
    chk("arst_rx", uart_rx, 2'b11);
    chk("arst_flt", line_fault, 0);
    chk("arst_brk", break_det, 0);
    rs232_rx = {NEG12, NEG12};
    tick(2);
    rst_n = 1'b1;
`ifdef RS232_LOOPBACK_EN
    lpbk = 2'b01;
    tx_en = 2'b01;
    uart_tx = 2'b01;
    rs232_rx[5:0] = POS12;
    tick(10);
    chk("lb_idle", uart_rx, 2'b11);
    chk("lb_tx0", rs232_tx, 0);
    for (int t = 0; t < 4; t++) begin
      uart_tx[0] = t[0];
      tick(5);
      chk("lb_lat", uart_rx[0], !t[0]);
      tick(1);
      chk("lb_follow", uart_rx[0], t[0]);
      chk("lb_txz", rs232_tx[5:0], 0);
      tick(14);
    end
`endif
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
